controle_multiciclo: RTL and testbench
======================================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk (rising edge) and rst (1 = reset, acts immediately, independent of clk).
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register.
REQ-005 zero  input  1  ALU equality flag, used only for beq.
REQ-006 estado  output  4  current state code, consumed directly by the memory stage.
REQ-007 Strobe outputs SHALL be 1 bit each: irwrite, pcwrite, pcwritecond, memread, memwrite, regwrite, memtoreg, alusrc, ilegal.
REQ-008 aluop  output  2  ALU operation: 00 add, 01 sub, 10 R-type by funct, 11 I-type by funct.
REQ-009 ninstr  output  16  count of fetched instructions.

Function
REQ-010 State codes SHALL be: FETCH 0000, DECODE 0001, ADDR 0010, MEM_READ 0011, WB_LOAD 0100, EXEC_R 0101, MEM_WRITE 0110, ALU_PASS 0111, WB_ALU 1000, BRANCH 1001, EXEC_I 1010; codes 1011-1111 are unused.
REQ-011 In DECODE, opcode SHALL be latched into an internal register, and later states SHALL use only the latched value.
REQ-012 FETCH SHALL go to DECODE, with irwrite=1, pcwrite=1, aluop=00 and alusrc=1.
REQ-013 DECODE transitions SHALL be: 0000011 (lw) or 0100011 (sw) -> ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; any other opcode -> FETCH with ilegal=1 for that cycle.
REQ-014 ADDR SHALL use aluop=00 and alusrc=1, then go to MEM_READ for lw or MEM_WRITE for sw.
REQ-015 MEM_READ SHALL assert memread=1, then go to WB_LOAD.
REQ-016 WB_LOAD SHALL assert regwrite=1 and memtoreg=1, then go to FETCH.
REQ-017 MEM_WRITE SHALL assert memwrite=1, then go to FETCH.
REQ-018 EXEC_R (aluop=10, alusrc=0) and EXEC_I (aluop=11, alusrc=1) SHALL each go to ALU_PASS.
REQ-019 ALU_PASS SHALL assert all strobes 0, so the memory stage latches the ALU result; it SHALL then go to WB_ALU.
REQ-020 WB_ALU SHALL assert regwrite=1 and memtoreg=0, then go to FETCH.
REQ-021 BRANCH SHALL assert aluop=01, alusrc=0 and pcwritecond=1, then go to FETCH; the PC update is qualified externally by zero, and the block's sequencing SHALL be independent of zero.
REQ-022 Instruction latency from FETCH back to FETCH SHALL be: lw 5 cycles, R/I 5, sw 4, beq 3, illegal 2.
REQ-023 Any unused state code SHALL return to FETCH on the next edge with all strobes 0.
REQ-024 Outputs SHALL be a pure function of the state register and latched opcode (Moore), with no combinational path from opcode or zero.
REQ-025 Any strobe not explicitly listed for a state SHALL be 0 in that state.
REQ-026 memread and memwrite SHALL never be 1 in the same cycle.
REQ-027 ninstr SHALL increment by 1 on each clk edge taken while in FETCH with rst=0, and SHALL wrap from 16'hFFFF to 16'h0000.

Reset
REQ-028 While rst=1: estado=0000, ninstr=0, latched opcode=0, and all strobes and aluop SHALL be 0, with FETCH strobes gated off.
REQ-029 Reset asserted mid-instruction SHALL abort that instruction immediately, with no further memwrite or regwrite pulse.
REQ-030 On the first rising edge after rst falls, the block SHALL be in FETCH with normal FETCH strobes and ninstr=0; that edge SHALL make ninstr=1.

Structure
REQ-031 A shared package SHALL hold the state codes, the opcode constants (lw, sw, R, I, beq) and the aluop codes, so that the memory stage and the datapath decode estado identically.
REQ-032 One combinational sub-module, controle_saidas, SHALL map (estado, latched opcode) to the strobes and aluop.
REQ-033 The next-state register, opcode latch and ninstr counter SHALL stay in controle_multiciclo.

Verification
REQ-034 lw: release rst, opcode=0000011 -> estado 0000,0001,0010,0011,0100,0000; memread=1 only in 0011; regwrite=memtoreg=1 only in 0100.
REQ-035 sw then add: opcode=0100011 -> 0000,0001,0010,0110,0000 with memwrite=1 only in 0110; then 0110011 -> 0000,0001,0101,0111,1000,0000 with aluop=10 in 0101.
REQ-036 beq with zero toggling every cycle -> 0000,0001,1001,0000 every time; pcwritecond=1 only in 1001.
REQ-037 Opcode 1111111 -> 0000,0001 (ilegal=1),0000; no memread, memwrite or regwrite pulse.
REQ-038 Assert rst asynchronously in 0110 mid-cycle -> memwrite falls immediately, estado=0000, ninstr=0; after release, lw sequence is correct.
REQ-039 Preload 65535 fetches -> ninstr=16'hFFFF; one more FETCH edge -> 16'h0000.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the state codes (also decoded by the memory stage and the datapath
// from estado), the opcode constants of the supported instructions, the aluop
// codes, and the bundle of strobes produced by the output decoder.
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'b0000,
    S_DECODE    = 4'b0001,
    S_ADDR      = 4'b0010,
    S_MEM_READ  = 4'b0011,
    S_WB_LOAD   = 4'b0100,
    S_EXEC_R    = 4'b0101,
    S_MEM_WRITE = 4'b0110,
    S_ALU_PASS  = 4'b0111,
    S_WB_ALU    = 4'b1000,
    S_BRANCH    = 4'b1001,
    S_EXEC_I    = 4'b1010
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       ilegal;
    logic [1:0] aluop;
  } ctl_t;

  // True for the five opcodes this control unit sequences.
  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/controle_multiciclo_saidas.sv
// controle_saidas: purely combinational output decoder.
// Ports:
//   estado     in  current state register
//   opcode_lat in  opcode latched for the current instruction
//   ctl        out strobes and aluop for this state
// Every strobe defaults to 0; each state raises only what it needs, and any
// unused state code falls through with everything at 0.
module controle_saidas
  import controle_multiciclo_pkg::*;
(
  input  state_t     estado,
  input  logic [6:0] opcode_lat,
  output ctl_t       ctl
);

  always_comb begin
    ctl = '0;
    case (estado)
      S_FETCH: begin
        ctl.irwrite = 1'b1;
        ctl.pcwrite = 1'b1;
        ctl.aluop   = ALU_ADD;
        ctl.alusrc  = 1'b1;
      end
      S_DECODE: begin
        ctl.ilegal = !is_known_op(opcode_lat);
      end
      S_ADDR: begin
        ctl.aluop  = ALU_ADD;
        ctl.alusrc = 1'b1;
      end
      S_MEM_READ: begin
        ctl.memread = 1'b1;
      end
      S_WB_LOAD: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctl.memwrite = 1'b1;
      end
      S_EXEC_R: begin
        ctl.aluop  = ALU_RTYPE;
        ctl.alusrc = 1'b0;
      end
      S_EXEC_I: begin
        ctl.aluop  = ALU_ITYPE;
        ctl.alusrc = 1'b1;
      end
      S_WB_ALU: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b0;
      end
      S_BRANCH: begin
        ctl.aluop       = ALU_SUB;
        ctl.alusrc      = 1'b0;
        ctl.pcwritecond = 1'b1;
      end
      default: ctl = '0;  // ALU_PASS and unused codes
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore control FSM for a multicycle RISC-V-style core.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   opcode[6:0]         instruction opcode from the instruction register
//   zero                ALU equality flag (qualifies pcwritecond outside)
//   estado[3:0]         current state code
//   irwrite .. ilegal   1-bit control strobes
//   aluop[1:0]          00 add, 01 sub, 10 R-type, 11 I-type
//   ninstr[15:0]        count of fetched instructions (wraps)
// Outputs depend only on the state register and the latched opcode; the
// opcode input only feeds the latch, and zero feeds nothing.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  output logic [3:0]  estado,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pcwritecond,
  output logic        memread,
  output logic        memwrite,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        alusrc,
  output logic        ilegal,
  output logic [1:0]  aluop,
  output logic [15:0] ninstr
);

  state_t      state;
  state_t      next_state;
  logic [6:0]  opcode_lat;
  logic [15:0] ninstr_q;
  ctl_t        ctl;
  ctl_t        ctl_out;

  // Branch sequencing ignores zero; the PC update is qualified externally.
  logic zero_unused;
  assign zero_unused = zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // The opcode is captured on the edge that enters DECODE, so DECODE and
  // every later state work from the register and the outputs stay Moore.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   opcode_lat <= '0;
    else if (state == S_FETCH) opcode_lat <= opcode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ninstr_q <= '0;
    else if (state == S_FETCH) ninstr_q <= ninstr_q + 16'd1;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (opcode_lat)
          OP_LW, OP_SW: next_state = S_ADDR;
          OP_R:         next_state = S_EXEC_R;
          OP_I:         next_state = S_EXEC_I;
          OP_BEQ:       next_state = S_BRANCH;
          default:      next_state = S_FETCH;
        endcase
      end
      S_ADDR:      next_state = (opcode_lat == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = S_WB_LOAD;
      S_WB_LOAD:   next_state = S_FETCH;
      S_MEM_WRITE: next_state = S_FETCH;
      S_EXEC_R:    next_state = S_ALU_PASS;
      S_EXEC_I:    next_state = S_ALU_PASS;
      S_ALU_PASS:  next_state = S_WB_ALU;
      S_WB_ALU:    next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      default:     next_state = S_FETCH;
    endcase
  end

  controle_saidas u_saidas (
    .estado     (state),
    .opcode_lat (opcode_lat),
    .ctl        (ctl)
  );

  // While reset is held the state already reads FETCH; mask its strobes so
  // nothing is written until reset is released.
  always_comb begin
    ctl_out = ctl;
    if (rst) ctl_out = '0;
  end

  assign estado      = state;
  assign irwrite     = ctl_out.irwrite;
  assign pcwrite     = ctl_out.pcwrite;
  assign pcwritecond = ctl_out.pcwritecond;
  assign memread     = ctl_out.memread;
  assign memwrite    = ctl_out.memwrite;
  assign regwrite    = ctl_out.regwrite;
  assign memtoreg    = ctl_out.memtoreg;
  assign alusrc      = ctl_out.alusrc;
  assign ilegal      = ctl_out.ilegal;
  assign aluop       = ctl_out.aluop;
  assign ninstr      = ninstr_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo. Outputs are sampled on the falling
// edge; the strobe vector is {irwrite,pcwrite,pcwritecond,memread,memwrite,
// regwrite,memtoreg,alusrc,ilegal,aluop[1:0]}.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic [3:0]  estado;
  logic        irwrite, pcwrite, pcwritecond, memread, memwrite;
  logic        regwrite, memtoreg, alusrc, ilegal;
  logic [1:0]  aluop;
  logic [15:0] ninstr;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_n = 16'd0;
  logic        toggle_zero = 1'b0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  localparam logic [10:0] C_NONE  = 11'b00000000000;
  localparam logic [10:0] C_FETCH = 11'b11000001000;
  localparam logic [10:0] C_ILL   = 11'b00000000100;
  localparam logic [10:0] C_ADDR  = 11'b00000001000;
  localparam logic [10:0] C_MRD   = 11'b00010000000;
  localparam logic [10:0] C_WBL   = 11'b00000110000;
  localparam logic [10:0] C_MWR   = 11'b00001000000;
  localparam logic [10:0] C_EXR   = 11'b00000000010;
  localparam logic [10:0] C_EXI   = 11'b00000001011;
  localparam logic [10:0] C_WBA   = 11'b00000100000;
  localparam logic [10:0] C_BR    = 11'b00100000001;

  controle_multiciclo dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .estado      (estado),
    .irwrite     (irwrite),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .memread     (memread),
    .memwrite    (memwrite),
    .regwrite    (regwrite),
    .memtoreg    (memtoreg),
    .alusrc      (alusrc),
    .ilegal      (ilegal),
    .aluop       (aluop),
    .ninstr      (ninstr)
  );

  always #5 clk = ~clk;

  // Compare the current outputs against the expected state, strobes, count.
  task automatic chk(input string tag, input logic [3:0] st, input logic [10:0] c);
    logic [10:0] got;
    got = {irwrite, pcwrite, pcwritecond, memread, memwrite,
           regwrite, memtoreg, alusrc, ilegal, aluop};
    vec_cnt++;
    assert (estado === st) else begin
      err_cnt++;
      $error("FAIL %s estado got %b exp %b", tag, estado, st);
    end
    vec_cnt++;
    assert (got === c) else begin
      err_cnt++;
      $error("FAIL %s strobes got %b exp %b", tag, got, c);
    end
    vec_cnt++;
    assert (ninstr === exp_n) else begin
      err_cnt++;
      $error("FAIL %s ninstr got %h exp %h", tag, ninstr, exp_n);
    end
  endtask

  // Check, then advance one full clock to the next falling edge.
  task automatic stp(input string tag, input logic [3:0] st, input logic [10:0] c);
    chk(tag, st, c);
    if (toggle_zero) zero = ~zero;
    @(negedge clk);
    if (st == 4'b0000 && rst == 1'b0) exp_n = exp_n + 16'd1;
  endtask

  initial begin
    rst    = 1'b1;
    opcode = LW;
    zero   = 1'b0;
    @(negedge clk);
    // Held reset: FETCH code, strobes masked, counter frozen across edges.
    stp("rst_a", 4'b0000, C_NONE);
    stp("rst_b", 4'b0000, C_NONE);

    rst = 1'b0;
    #1;
    // lw; opcode scrambled after DECODE must not change the path.
    stp("lw_fetch", 4'b0000, C_FETCH);
    stp("lw_dec",   4'b0001, C_NONE);
    opcode = BAD;
    stp("lw_addr",  4'b0010, C_ADDR);
    opcode = SW;
    stp("lw_mrd",   4'b0011, C_MRD);
    stp("lw_wb",    4'b0100, C_WBL);

    opcode = SW;
    stp("sw_fetch", 4'b0000, C_FETCH);
    stp("sw_dec",   4'b0001, C_NONE);
    stp("sw_addr",  4'b0010, C_ADDR);
    stp("sw_mwr",   4'b0110, C_MWR);

    opcode = RT;
    stp("r_fetch",  4'b0000, C_FETCH);
    stp("r_dec",    4'b0001, C_NONE);
    stp("r_exec",   4'b0101, C_EXR);
    stp("r_pass",   4'b0111, C_NONE);
    stp("r_wb",     4'b1000, C_WBA);

    opcode = IT;
    stp("i_fetch",  4'b0000, C_FETCH);
    stp("i_dec",    4'b0001, C_NONE);
    stp("i_exec",   4'b1010, C_EXI);
    stp("i_pass",   4'b0111, C_NONE);
    stp("i_wb",     4'b1000, C_WBA);

    // beq twice with zero toggling every cycle.
    opcode = BEQ;
    toggle_zero = 1'b1;
    stp("beq0_fetch", 4'b0000, C_FETCH);
    stp("beq0_dec",   4'b0001, C_NONE);
    stp("beq0_br",    4'b1001, C_BR);
    stp("beq1_fetch", 4'b0000, C_FETCH);
    stp("beq1_dec",   4'b0001, C_NONE);
    stp("beq1_br",    4'b1001, C_BR);
    toggle_zero = 1'b0;

    opcode = BAD;
    stp("ill_fetch", 4'b0000, C_FETCH);
    stp("ill_dec",   4'b0001, C_ILL);

    // sw aborted by reset in the middle of MEM_WRITE.
    opcode = SW;
    stp("swr_fetch", 4'b0000, C_FETCH);
    stp("swr_dec",   4'b0001, C_NONE);
    stp("swr_addr",  4'b0010, C_ADDR);
    chk("swr_mwr",   4'b0110, C_MWR);
    #2;
    rst = 1'b1;
    #1;
    exp_n = 16'd0;
    chk("swr_abort", 4'b0000, C_NONE);
    @(negedge clk);
    chk("swr_hold",  4'b0000, C_NONE);
    rst = 1'b0;
    #1;
    opcode = LW;
    stp("lw2_fetch", 4'b0000, C_FETCH);
    stp("lw2_dec",   4'b0001, C_NONE);
    stp("lw2_addr",  4'b0010, C_ADDR);
    stp("lw2_mrd",   4'b0011, C_MRD);
    stp("lw2_wb",    4'b0100, C_WBL);

    // Counter wrap: preload the count just below the top while in FETCH.
    opcode = BAD;
    force dut.ninstr_q = 16'hFFFE;
    #1;
    release dut.ninstr_q;
    exp_n = 16'hFFFE;
    stp("wrap_f0", 4'b0000, C_FETCH);
    stp("wrap_d0", 4'b0001, C_ILL);
    stp("wrap_f1", 4'b0000, C_FETCH);
    chk("wrap_d1", 4'b0001, C_ILL);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
